// File: rtl/pwm_regs_mc.sv
// pwm_regs_mc: byte-addressed register file for NUM_CH PWM channels with atomic 16-bit commits.
// Define PWM_REGS_SYNC_UPDATE_EN to shadow period/compare outputs until period_end (or while disabled).
module pwm_regs_mc #(
  parameter int          NUM_CH     = 2,
  parameter logic [15:0] RST_PERIOD = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read,
  input  logic                 write,
  input  logic [5:0]           addr,
  input  logic [7:0]           data_write,
  output logic [7:0]           data_read,
  output logic                 addr_err,
  input  logic [16*NUM_CH-1:0] counter_val,
  input  logic [NUM_CH-1:0]    period_end,
  output logic [16*NUM_CH-1:0] period,
  output logic [16*NUM_CH-1:0] compare1,
  output logic [16*NUM_CH-1:0] compare2,
  output logic [8*NUM_CH-1:0]  prescale,
  output logic [2*NUM_CH-1:0]  functions,
  output logic [NUM_CH-1:0]    en,
  output logic [NUM_CH-1:0]    count_reset,
  output logic [NUM_CH-1:0]    upnotdown,
  output logic [NUM_CH-1:0]    pwm_en
);
  logic [1:0]          ch;
  logic [3:0]          off;
  logic                valid;
  logic [8*NUM_CH-1:0] rd_all;
  logic [7:0]          rd_sel, data_read_q, data_read_d;
  logic                addr_err_q, addr_err_d;
  assign ch    = addr[5:4];
  assign off   = addr[3:0];
  assign valid = (32'(ch) < NUM_CH) && (off < 4'hE);
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) rd_sel = (ch == 2'(i)) ? rd_all[8*i+:8] : rd_sel;
  end
  assign data_read_d = read ? (valid ? rd_sel : 8'h00) : data_read_q;
  assign addr_err_d  = (read | write) & ~valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      data_read_q <= 8'h00;
      addr_err_q  <= 1'b0;
    end else begin
      data_read_q <= data_read_d;
      addr_err_q  <= addr_err_d;
    end
  end
  assign data_read = data_read_q;
  assign addr_err  = addr_err_q;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic        hit, wr;
    logic [15:0] cnt, per_q, per_d, cmp1_q, cmp1_d, cmp2_q, cmp2_d, snap_q, snap_d;
    logic [7:0]  per_stg_q, per_stg_d, cmp1_stg_q, cmp1_stg_d, cmp2_stg_q, cmp2_stg_d;
    logic [7:0]  pre_q, pre_d, rd;
    logic        en_q, en_d, ud_q, ud_d, pe_q, pe_d;
    logic [1:0]  fn_q, fn_d, cr_q, cr_d;
    assign hit = valid && (ch == 2'(c));
    assign wr  = write && hit;
    assign cnt = counter_val[16*c+:16];
    always_comb begin
      per_stg_d  = (wr && off == 4'h0) ? data_write : per_stg_q;
      per_d      = (wr && off == 4'h1) ? {data_write, per_stg_q} : per_q;
      en_d       = (wr && off == 4'h2) ? data_write[0] : en_q;
      cmp1_stg_d = (wr && off == 4'h3) ? data_write : cmp1_stg_q;
      cmp1_d     = (wr && off == 4'h4) ? {data_write, cmp1_stg_q} : cmp1_q;
      cmp2_stg_d = (wr && off == 4'h5) ? data_write : cmp2_stg_q;
      cmp2_d     = (wr && off == 4'h6) ? {data_write, cmp2_stg_q} : cmp2_q;
      cr_d       = (wr && off == 4'h7 && data_write[0]) ? 2'd2 : ((cr_q != 2'd0) ? cr_q - 2'd1 : 2'd0);
      snap_d     = (read && hit && off == 4'h8) ? cnt : snap_q;
      pre_d      = (wr && off == 4'hA) ? data_write : pre_q;
      ud_d       = (wr && off == 4'hB) ? data_write[0] : ud_q;
      pe_d       = (wr && off == 4'hC) ? data_write[0] : pe_q;
      fn_d       = (wr && off == 4'hD) ? data_write[1:0] : fn_q;
    end
    always_comb begin
      case (off)
        4'h0:    rd = per_q[7:0];
        4'h1:    rd = per_q[15:8];
        4'h2:    rd = {7'b0, en_q};
        4'h3:    rd = cmp1_q[7:0];
        4'h4:    rd = cmp1_q[15:8];
        4'h5:    rd = cmp2_q[7:0];
        4'h6:    rd = cmp2_q[15:8];
        4'h8:    rd = cnt[7:0];
        4'h9:    rd = snap_q[15:8];
        4'hA:    rd = pre_q;
        4'hB:    rd = {7'b0, ud_q};
        4'hC:    rd = {7'b0, pe_q};
        4'hD:    rd = {6'b0, fn_q};
        default: rd = 8'h00;
      endcase
    end
    assign rd_all[8*c+:8] = rd;
    always_ff @(posedge clk) begin
      if (rst) begin
        per_q <= RST_PERIOD;
        {cmp1_q, cmp2_q, snap_q} <= '0;
        {per_stg_q, cmp1_stg_q, cmp2_stg_q, pre_q} <= '0;
        {en_q, ud_q, pe_q, fn_q, cr_q} <= '0;
      end else begin
        per_q      <= per_d;
        cmp1_q     <= cmp1_d;
        cmp2_q     <= cmp2_d;
        snap_q     <= snap_d;
        per_stg_q  <= per_stg_d;
        cmp1_stg_q <= cmp1_stg_d;
        cmp2_stg_q <= cmp2_stg_d;
        pre_q      <= pre_d;
        en_q       <= en_d;
        ud_q       <= ud_d;
        pe_q       <= pe_d;
        fn_q       <= fn_d;
        cr_q       <= cr_d;
      end
    end
`ifdef PWM_REGS_SYNC_UPDATE_EN
    // Shadows take the freshly committed value, so a commit coinciding with the load condition is not lost.
    logic [15:0] per_o_q, cmp1_o_q, cmp2_o_q;
    logic        load;
    assign load = period_end[c] | ~en_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        per_o_q  <= RST_PERIOD;
        cmp1_o_q <= '0;
        cmp2_o_q <= '0;
      end else if (load) begin
        per_o_q  <= per_d;
        cmp1_o_q <= cmp1_d;
        cmp2_o_q <= cmp2_d;
      end
    end
    assign period[16*c+:16]   = per_o_q;
    assign compare1[16*c+:16] = cmp1_o_q;
    assign compare2[16*c+:16] = cmp2_o_q;
`else
    logic unused_pe;
    assign unused_pe          = period_end[c];
    assign period[16*c+:16]   = per_q;
    assign compare1[16*c+:16] = cmp1_q;
    assign compare2[16*c+:16] = cmp2_q;
`endif
    assign prescale[8*c+:8]  = pre_q;
    assign functions[2*c+:2] = fn_q;
    assign en[c]             = en_q;
    assign count_reset[c]    = cr_q != 2'd0;
    assign upnotdown[c]      = ud_q;
    assign pwm_en[c]         = pe_q;
  end
endmodule

// File: tb/tb_pwm_regs_mc.sv
// tb_pwm_regs_mc: directed vector table, corner sequences and randomized run against a register-map model.
module tb_pwm_regs_mc;
  localparam int          N  = 2;
  localparam logic [15:0] RP = 16'h00C3;
  logic            clk = 1'b0, rst = 1'b1, read = 1'b0, write = 1'b0;
  logic [5:0]      addr = '0;
  logic [7:0]      data_write = '0, data_read;
  logic            addr_err;
  logic [16*N-1:0] counter_val = '0, period, compare1, compare2;
  logic [N-1:0]    period_end = '0, en, count_reset, upnotdown, pwm_en;
  logic [8*N-1:0]  prescale;
  logic [2*N-1:0]  functions;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  pwm_regs_mc #(.NUM_CH(N), .RST_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .data_write(data_write),
    .data_read(data_read), .addr_err(addr_err), .counter_val(counter_val), .period_end(period_end),
    .period(period), .compare1(compare1), .compare2(compare2), .prescale(prescale),
    .functions(functions), .en(en), .count_reset(count_reset), .upnotdown(upnotdown), .pwm_en(pwm_en)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d);
    read = r; write = w; addr = a; data_write = d;
    tick();
    read = 1'b0; write = 1'b0;
  endtask
  task automatic reset_check(input string tag);
    chk({tag, " data_read"}, 32'(data_read), 32'h0);
    chk({tag, " addr_err"}, 32'(addr_err), 32'h0);
    chk({tag, " period"}, period, {RP, RP});
    chk({tag, " compare1"}, compare1, 32'h0);
    chk({tag, " compare2"}, compare2, 32'h0);
    chk({tag, " prescale"}, 32'(prescale), 32'h0);
    chk({tag, " functions"}, 32'(functions), 32'h0);
    chk({tag, " en"}, 32'(en), 32'h0);
    chk({tag, " count_reset"}, 32'(count_reset), 32'h0);
    chk({tag, " upnotdown"}, 32'(upnotdown), 32'h0);
    chk({tag, " pwm_en"}, 32'(pwm_en), 32'h0);
  endtask

  // Reference model: registers held per channel by kind (0 period, 1 compare1, 2 compare2).
  logic [15:0] m_prog [N][3];
  logic [15:0] m_out  [N][3];
  logic [7:0]  m_stg  [N][3];
  logic [15:0] m_snap [N];
  logic [7:0]  m_pre  [N];
  logic        m_en [N], m_ud [N], m_pe [N];
  logic [1:0]  m_fn [N];
  int          m_crl [N];
  logic [7:0]  m_dr;
  logic        m_err;
  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 3; k++) begin
        m_prog[i][k] = (k == 0) ? RP : 16'h0;
        m_out[i][k]  = m_prog[i][k];
        m_stg[i][k]  = 8'h0;
      end
      m_snap[i] = 0; m_pre[i] = 0; m_en[i] = 0; m_ud[i] = 0; m_pe[i] = 0; m_fn[i] = 0; m_crl[i] = 0;
    end
    m_dr = 0; m_err = 0;
  endtask
  function automatic int kind_of(int o);
    return (o < 2) ? 0 : (o < 5) ? 1 : 2;
  endfunction
  function automatic logic [7:0] m_read(int c, int o, logic [15:0] cv);
    logic [15:0] v;
    if (o inside {0, 1, 3, 4, 5, 6}) begin
      v = m_prog[c][kind_of(o)];
      return (o inside {1, 4, 6}) ? v[15:8] : v[7:0];
    end
    v = m_snap[c];
    case (o)
      2:       return {7'b0, m_en[c]};
      8:       return cv[7:0];
      9:       return v[15:8];
      10:      return m_pre[c];
      11:      return {7'b0, m_ud[c]};
      12:      return {7'b0, m_pe[c]};
      13:      return {6'b0, m_fn[c]};
      default: return 8'h00;
    endcase
  endfunction
  task automatic m_step(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d,
                        input logic [16*N-1:0] cv, input logic [N-1:0] pe, input logic rs);
    int c, o;
    logic v;
    logic oe [N];
    if (rs) begin
      m_reset();
      return;
    end
    c = int'(a[5:4]); o = int'(a[3:0]);
    v = (c < N) && (o < 14);
    oe = m_en;
    m_err = (r || w) && !v;
    if (r) m_dr = v ? m_read(c, o, cv[16*c+:16]) : 8'h00;
    if (r && v && o == 8) m_snap[c] = cv[16*c+:16];
    for (int i = 0; i < N; i++) if (m_crl[i] > 0) m_crl[i]--;
    if (w && v) begin
      if (o inside {0, 3, 5}) m_stg[c][kind_of(o)] = d;
      if (o inside {1, 4, 6}) m_prog[c][kind_of(o)] = {d, m_stg[c][kind_of(o)]};
      case (o)
        2:  m_en[c] = d[0];
        7:  if (d[0]) m_crl[c] = 2;
        10: m_pre[c] = d;
        11: m_ud[c] = d[0];
        12: m_pe[c] = d[0];
        13: m_fn[c] = d[1:0];
        default: ;
      endcase
    end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) begin
`ifdef PWM_REGS_SYNC_UPDATE_EN
        if (pe[i] || !oe[i]) m_out[i][k] = m_prog[i][k];
`else
        m_out[i][k] = m_prog[i][k];
`endif
      end
  endtask
  task automatic cmp_all();
    logic [16*N-1:0] ep, e1, e2;
    logic [8*N-1:0]  epr;
    logic [2*N-1:0]  efn;
    logic [N-1:0]    een, ecr, eud, epe;
    for (int i = 0; i < N; i++) begin
      ep[16*i+:16] = m_out[i][0]; e1[16*i+:16] = m_out[i][1]; e2[16*i+:16] = m_out[i][2];
      epr[8*i+:8] = m_pre[i]; efn[2*i+:2] = m_fn[i];
      een[i] = m_en[i]; ecr[i] = m_crl[i] > 0; eud[i] = m_ud[i]; epe[i] = m_pe[i];
    end
    chk("rnd data_read", 32'(data_read), 32'(m_dr));
    chk("rnd addr_err", 32'(addr_err), 32'(m_err));
    chk("rnd period", period, ep);
    chk("rnd compare1", compare1, e1);
    chk("rnd compare2", compare2, e2);
    chk("rnd prescale", 32'(prescale), 32'(epr));
    chk("rnd functions", 32'(functions), 32'(efn));
    chk("rnd en", 32'(en), 32'(een));
    chk("rnd count_reset", 32'(count_reset), 32'(ecr));
    chk("rnd upnotdown", 32'(upnotdown), 32'(eud));
    chk("rnd pwm_en", 32'(pwm_en), 32'(epe));
  endtask

  typedef struct {
    logic        rd, wr;
    logic [5:0]  a;
    logic [7:0]  d;
    logic [15:0] cv;
    logic [7:0]  dr;
    logic        err;
    logic [15:0] per0;
    logic        cr1;
  } vec_t;
  vec_t tv [15];

  initial begin
    logic [15:0] exp_c1;
    tv[0]  = '{1'b0, 1'b1, 6'h00, 8'h34, 16'h0000, 8'h00, 1'b0, 16'h00C3, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 6'h01, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h00C3, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 6'h01, 8'h12, 16'h0000, 8'h00, 1'b0, 16'h1234, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 6'h00, 8'h00, 16'h0000, 8'h34, 1'b0, 16'h1234, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 6'h08, 8'h00, 16'hABCD, 8'hCD, 1'b0, 16'h1234, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 6'h09, 8'h00, 16'h0000, 8'hAB, 1'b0, 16'h1234, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 6'h20, 8'h55, 16'h0000, 8'hAB, 1'b1, 16'h1234, 1'b0};
    tv[7]  = '{1'b1, 1'b0, 6'h0E, 8'h00, 16'h0000, 8'h00, 1'b1, 16'h1234, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 6'h00, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h1234, 1'b0};
    tv[9]  = '{1'b0, 1'b1, 6'h17, 8'h01, 16'h0000, 8'h00, 1'b0, 16'h1234, 1'b1};
    tv[10] = '{1'b0, 1'b0, 6'h00, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h1234, 1'b1};
    tv[11] = '{1'b0, 1'b0, 6'h00, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h1234, 1'b0};
    tv[12] = '{1'b1, 1'b1, 6'h01, 8'h56, 16'h0000, 8'h12, 1'b0, 16'h5634, 1'b0};
    tv[13] = '{1'b0, 1'b1, 6'h17, 8'hFE, 16'h0000, 8'h12, 1'b0, 16'h5634, 1'b0};
    tv[14] = '{1'b1, 1'b0, 6'h17, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h5634, 1'b0};
    tick();
    reset_check("reset");
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      read = tv[i].rd; write = tv[i].wr; addr = tv[i].a; data_write = tv[i].d;
      counter_val = {16'h0000, tv[i].cv};
      tick();
      read = 1'b0; write = 1'b0;
      chk($sformatf("vec%0d data_read", i), 32'(data_read), 32'(tv[i].dr));
      chk($sformatf("vec%0d addr_err", i), 32'(addr_err), 32'(tv[i].err));
      chk($sformatf("vec%0d period0", i), 32'(period[15:0]), 32'(tv[i].per0));
      chk($sformatf("vec%0d count_reset1", i), 32'(count_reset[1]), 32'(tv[i].cr1));
    end
    // count_reset restart on the second pulse cycle
    drv(1'b0, 1'b1, 6'h17, 8'h01);
    chk("ext c1", 32'(count_reset[1]), 32'h1);
    tick();
    chk("ext c2", 32'(count_reset[1]), 32'h1);
    drv(1'b0, 1'b1, 6'h17, 8'h01);
    chk("ext c3", 32'(count_reset[1]), 32'h1);
    tick();
    chk("ext c4", 32'(count_reset[1]), 32'h1);
    tick();
    chk("ext c5", 32'(count_reset[1]), 32'h0);
    // compare1 commit while enabled
    drv(1'b0, 1'b1, 6'h02, 8'h01);
    chk("en0 set", 32'(en), 32'h1);
    drv(1'b0, 1'b1, 6'h03, 8'h50);
    drv(1'b0, 1'b1, 6'h04, 8'h00);
`ifdef PWM_REGS_SYNC_UPDATE_EN
    exp_c1 = 16'h0000;
`else
    exp_c1 = 16'h0050;
`endif
    chk("cmp1 commit", 32'(compare1[15:0]), 32'(exp_c1));
    tick();
    chk("cmp1 hold", 32'(compare1[15:0]), 32'(exp_c1));
    period_end = 2'b01;
    tick();
    period_end = 2'b00;
    chk("cmp1 after period_end", 32'(compare1[15:0]), 32'h0050);
    // reset mid-pulse and mid-staging
    drv(1'b0, 1'b1, 6'h17, 8'h01);
    drv(1'b0, 1'b1, 6'h05, 8'h77);
    chk("stage no change", 32'(compare2[15:0]), 32'h0);
    chk("pulse active", 32'(count_reset[1]), 32'h1);
    rst = 1'b1;
    tick();
    reset_check("midrst");
    rst = 1'b0;
    drv(1'b0, 1'b1, 6'h06, 8'h00);
    chk("stage discarded", 32'(compare2[15:0]), 32'h0);
    drv(1'b1, 1'b0, 6'h09, 8'h00);
    chk("snapshot reset", 32'(data_read), 32'h0);
    // randomized run against the model
    rst = 1'b1;
    tick();
    m_reset();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      read = 1'($urandom); write = 1'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? 6'($urandom) : {1'b0, 5'($urandom)};
      data_write = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom);
      counter_val = 32'($urandom);
      period_end = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      m_step(read, write, addr, data_write, counter_val, period_end, rst);
      tick();
      cmp_all();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
